rom_arbiter: RTL and testbench

Sequencing controller that shares one asynchronous, active-low-enabled ROM between two synchronous requesters (CPU fetch port 0, loader/debug port 1). It arbitrates requests, drives the ROM address and the CS/OE strobes with a configurable number of wait states, captures the read word into a register, and returns it with a one-cycle acknowledge. It sits between the requesters and the ROM and is the only block that drives the ROM address and strobes.

---
 rtl/rom_arb_pkg.sv | 24 ++
 rtl/rom_arbiter_if.sv | 38 +++
 rtl/rom_arb_pick.sv | 33 +++
 rtl/rom_arbiter.sv | 123 ++++++++++++
 tb/tb_rom_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rom_arb_pkg.sv
// -----------------------------------------------------------------------------
// rom_arb_pkg
// Shared definitions for the ROM arbiter slice: the controller state encoding,
// the requester port indices and the width of the strobe wait counter.
// No ports (package).
// -----------------------------------------------------------------------------
package rom_arb_pkg;

   // Controller states, in the order a read walks through them
   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      STROBE,
      DONE
   } arbState_e;

   // Requester indices as reported on owner
   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_AUX = 1'b1;

   // Wide enough for the full 0..15 wait-state range
   localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// rom_arbiter_if
// Bundles the two requester handshakes and the asynchronous ROM bus.
//   req0/req1, addr0/addr1 : requests from CPU fetch (0) and loader/debug (1)
//   ack0/ack1, rdata       : one-cycle acknowledge with the captured ROM word
//   owner, busy            : port of the current/last transaction, non-idle flag
//   rom_addr, rom_data     : ROM address out, ROM data in
//   rom_cs_n, rom_oe_n     : active-low ROM chip select and output enable
// Modports: slave = arbiter side, master = requesters plus ROM side.
// -----------------------------------------------------------------------------
interface rom_arbiter_if #(
   parameter int AddressSize = 16,
   parameter int WordSize    = 8
);
   logic                   req0;
   logic                   req1;
   logic [AddressSize-1:0] addr0;
   logic [AddressSize-1:0] addr1;
   logic                   ack0;
   logic                   ack1;
   logic [WordSize-1:0]    rdata;
   logic                   owner;
   logic                   busy;
   logic [AddressSize-1:0] rom_addr;
   logic [WordSize-1:0]    rom_data;
   logic                   rom_cs_n;
   logic                   rom_oe_n;

   modport slave (
      input  req0, req1, addr0, addr1, rom_data,
      output ack0, ack1, rdata, owner, busy, rom_addr, rom_cs_n, rom_oe_n
   );

   modport master (
      output req0, req1, addr0, addr1, rom_data,
      input  ack0, ack1, rdata, owner, busy, rom_addr, rom_cs_n, rom_oe_n
   );
endinterface

// File: rtl/rom_arb_pick.sv
// -----------------------------------------------------------------------------
// rom_arb_pick
// Combinational winner select between the two requesters.
//   req0_i, req1_i : pending requests
//   last_i         : port granted most recently (round-robin build only)
//   grant_o        : at least one request is pending
//   winner_o       : index of the port to serve
// Build option ROM_ARB_ROUND_ROBIN_EN: ties alternate away from last_i.
// Without it port 0 always wins a tie. A lone request always wins.
// -----------------------------------------------------------------------------
module rom_arb_pick
   import rom_arb_pkg::*;
(
   input  logic req0_i,
   input  logic req1_i,
`ifdef ROM_ARB_ROUND_ROBIN_EN
   input  logic last_i,
`endif
   output logic grant_o,
   output logic winner_o
);

   assign grant_o = req0_i | req1_i;

`ifdef ROM_ARB_ROUND_ROBIN_EN
   // On a tie hand the bus to whichever port did not get it last time
   assign winner_o = (req0_i & req1_i) ? ~last_i : (req0_i ? PORT_CPU : PORT_AUX);
`else
   // Port 0 wins whenever it asks; port 1 only wins when it is alone
   assign winner_o = req0_i ? PORT_CPU : PORT_AUX;
`endif

endmodule

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
// Shares one asynchronous, active-low-enabled ROM between two synchronous
// requesters. A read walks IDLE -> SETUP -> STROBE (WaitStates+1 cycles) ->
// DONE; the ROM word is captured at the end of STROBE and ack pulses in DONE.
//   clk     : system clock, all state changes on the rising edge
//   reset_n : synchronous active-low reset
//   bus     : rom_arbiter_if.slave (requests, acks, rdata, owner, busy, ROM bus)
// Parameters: AddressSize, WordSize, WaitStates (0..15).
// Build option ROM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
// -----------------------------------------------------------------------------
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int AddressSize = 16,
   parameter int WordSize    = 8,
   parameter int WaitStates  = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   rom_arbiter_if.slave bus
);

   arbState_e              state_q;
   logic [WAIT_CNT_W-1:0]  waitCnt_q;
   logic [AddressSize-1:0] romAddr_q;
   logic [WordSize-1:0]    rdata_q;
   logic                   owner_q;
   logic                   csN_q;
   logic                   oeN_q;
   logic                   ack0_q;
   logic                   ack1_q;
   logic                   grant;
   logic                   winner;
`ifdef ROM_ARB_ROUND_ROBIN_EN
   logic                   last_q;
`endif

   // Winner select only matters in IDLE; the FSM ignores it elsewhere
   rom_arb_pick u_pick (
      .req0_i   (bus.req0),
      .req1_i   (bus.req1),
`ifdef ROM_ARB_ROUND_ROBIN_EN
      .last_i   (last_q),
`endif
      .grant_o  (grant),
      .winner_o (winner)
   );

   // Controller: every ROM pin and handshake output comes straight from a
   // register here, so there is no combinational path from req to the ROM.
   // The strobes are set one edge ahead of the state they belong to.
   // The last-grant pointer starts at port 1 so that port 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         waitCnt_q <= '0;
         romAddr_q <= '0;
         rdata_q   <= '0;
         owner_q   <= PORT_CPU;
         csN_q     <= 1'b1;
         oeN_q     <= 1'b1;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
`ifdef ROM_ARB_ROUND_ROBIN_EN
         last_q    <= PORT_AUX;
`endif
      end else begin
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (grant) begin
                  romAddr_q <= winner ? bus.addr1 : bus.addr0;
                  owner_q   <= winner;
`ifdef ROM_ARB_ROUND_ROBIN_EN
                  last_q    <= winner;
`endif
                  csN_q     <= 1'b0;
                  oeN_q     <= 1'b1;
                  state_q   <= SETUP;
               end
            end
            SETUP: begin
               oeN_q     <= 1'b0;
               waitCnt_q <= WAIT_CNT_W'(WaitStates);
               state_q   <= STROBE;
            end
            STROBE: begin
               if (waitCnt_q == '0) begin
                  rdata_q <= bus.rom_data;
                  csN_q   <= 1'b1;
                  oeN_q   <= 1'b1;
                  if (owner_q == PORT_AUX) begin
                     ack1_q <= 1'b1;
                  end else begin
                     ack0_q <= 1'b1;
                  end
                  state_q <= DONE;
               end else begin
                  waitCnt_q <= waitCnt_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.rom_addr = romAddr_q;
   assign bus.rom_cs_n = csN_q;
   assign bus.rom_oe_n = oeN_q;
   assign bus.rdata    = rdata_q;
   assign bus.owner    = owner_q;
   assign bus.ack0     = ack0_q;
   assign bus.ack1     = ack1_q;
   assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
// Directed bench for rom_arbiter. dutA runs with WaitStates=2, dutB with
// WaitStates=0. Each has an asynchronous ROM model that only drives its
// image while both strobes are low. Tie-break expectations follow
// ROM_ARB_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

   logic clk;
   logic reset_n;

   int checks;
   int failures;

   int          ackCycle;
   int          ackCount;
   int          wrongAck;
   int          csLow;
   int          oeLow;
   logic [7:0]  dataSeen;
   logic [15:0] addrSeen;
   logic        gotAck;
   logic        ownerSeen;
   logic        ack1Seen;
   int          idx;
   int          bothAck;
   int          addrMoves;
   int          ackNoBusy;
   int          ackOwnerBad;
   int          ackTotal;
   logic        prevCsLow;
   logic [15:0] prevAddr;
   logic [31:0] r;
   logic        expOwner;
   logic [15:0] bAddr [4];

   rom_arbiter_if #(.AddressSize(16), .WordSize(8)) busA ();
   rom_arbiter_if #(.AddressSize(16), .WordSize(8)) busB ();

   rom_arbiter #(.AddressSize(16), .WordSize(8), .WaitStates(2)) dutA (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busA)
   );

   rom_arbiter #(.AddressSize(16), .WordSize(8), .WaitStates(0)) dutB (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (busB)
   );

   // ROM image used by both ROM models and by the expectations
   function automatic logic [7:0] romImage(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hB5;
   endfunction

   // Asynchronous ROMs: valid data only while selected and output-enabled
   assign busA.rom_data = (!busA.rom_cs_n && !busA.rom_oe_n) ? romImage(busA.rom_addr) : 8'hEE;
   assign busB.rom_data = (!busB.rom_cs_n && !busB.rom_oe_n) ? romImage(busB.rom_addr) : 8'hEE;

   // 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns
   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One read on busA: raise req, accept at the next edge, then watch 12
   // cycles counting strobes and acks; req drops on the ack (or at SETUP).
   task automatic applyStimulus(input logic port, input logic [15:0] addr, input bit dropAtSetup,
                                output int ackCyc, output int ackCnt, output int wrong,
                                output int csCnt, output int oeCnt,
                                output logic [7:0] data, output logic [15:0] addrAt1);
      ackCyc  = 0;
      ackCnt  = 0;
      wrong   = 0;
      csCnt   = 0;
      oeCnt   = 0;
      data    = 8'h00;
      addrAt1 = 16'h0000;
      @(negedge clk);
      if (port) begin
         busA.req1  = 1'b1;
         busA.addr1 = addr;
      end else begin
         busA.req0  = 1'b1;
         busA.addr0 = addr;
      end
      @(posedge clk);
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) addrAt1 = busA.rom_addr;
         if (!busA.rom_cs_n) csCnt++;
         if (!busA.rom_oe_n) oeCnt++;
         if (port ? busA.ack1 : busA.ack0) begin
            ackCnt++;
            ackCyc = k;
            data   = busA.rdata;
            busA.req0 = 1'b0;
            busA.req1 = 1'b0;
         end
         if (port ? busA.ack0 : busA.ack1) wrong++;
         if (k == 1 && dropAtSetup) begin
            busA.req0 = 1'b0;
            busA.req1 = 1'b0;
         end
      end
      busA.req0 = 1'b0;
      busA.req1 = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      bAddr    = '{16'h1234, 16'hBEEF, 16'h00FF, 16'h8001};
      reset_n  = 1'b0;
      busA.req0 = 1'b0; busA.req1 = 1'b0; busA.addr0 = '0; busA.addr1 = '0;
      busB.req0 = 1'b0; busB.req1 = 1'b0; busB.addr0 = '0; busB.addr1 = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_cs_n",  busA.rom_cs_n, 1);
      checkOutput("rst_oe_n",  busA.rom_oe_n, 1);
      checkOutput("rst_ack0",  busA.ack0, 0);
      checkOutput("rst_ack1",  busA.ack1, 0);
      checkOutput("rst_rdata", busA.rdata, 0);
      checkOutput("rst_addr",  busA.rom_addr, 0);
      checkOutput("rst_owner", busA.owner, 0);
      checkOutput("rst_busy",  busA.busy, 0);
      checkOutput("rstB_cs_n", busB.rom_cs_n, 1);
      reset_n = 1'b1;

      // WaitStates=2 single read
      applyStimulus(1'b0, 16'h0010, 1'b0, ackCycle, ackCount, wrongAck, csLow, oeLow, dataSeen, addrSeen);
      checkOutput("ws2_ack_cycle", ackCycle, 5);
      checkOutput("ws2_ack_count", ackCount, 1);
      checkOutput("ws2_wrong_ack", wrongAck, 0);
      checkOutput("ws2_rdata",     dataSeen, 8'hA5);
      checkOutput("ws2_cs_cycles", csLow, 4);
      checkOutput("ws2_oe_cycles", oeLow, 3);
      checkOutput("ws2_rom_addr",  addrSeen, 16'h0010);
      checkOutput("ws2_idle_busy", busA.busy, 0);

      // Simultaneous requests, starting from a fresh pointer
      @(negedge clk);
      reset_n = 1'b0;
      busA.req0 = 1'b1; busA.addr0 = 16'h0100;
      busA.req1 = 1'b1; busA.addr1 = 16'h0200;
      @(negedge clk);
      reset_n = 1'b1;
      for (int t = 0; t < 4; t++) begin
`ifdef ROM_ARB_ROUND_ROBIN_EN
         expOwner = (t % 2) == 1;
`else
         expOwner = 1'b0;
`endif
         gotAck    = 1'b0;
         ownerSeen = 1'b0;
         ack1Seen  = 1'b0;
         dataSeen  = 8'h00;
         for (int k = 0; k < 20 && !gotAck; k++) begin
            @(negedge clk);
            if (busA.ack0 || busA.ack1) begin
               gotAck    = 1'b1;
               ownerSeen = busA.owner;
               ack1Seen  = busA.ack1;
               dataSeen  = busA.rdata;
               if (t == 3) begin
                  busA.req0 = 1'b0;
                  busA.req1 = 1'b0;
               end
            end
         end
         checkOutput("tie_ack_seen", gotAck, 1);
         checkOutput("tie_owner",    ownerSeen, expOwner);
         checkOutput("tie_ack_port", ack1Seen, expOwner);
         checkOutput("tie_rdata",    dataSeen, romImage(expOwner ? 16'h0200 : 16'h0100));
      end
      busA.req0 = 1'b0;
      busA.req1 = 1'b0;
      repeat (3) @(negedge clk);

      // WaitStates=0 back-to-back on dutB, new address presented on each ack
      idx   = 0;
      csLow = 0;
      oeLow = 0;
      @(negedge clk);
      busB.req0  = 1'b1;
      busB.addr0 = bAddr[0];
      @(posedge clk);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!busB.rom_cs_n) csLow++;
         if (!busB.rom_oe_n) oeLow++;
         if (busB.ack0) begin
            if (idx < 4) begin
               checkOutput("ws0_ack_cycle", k, 3 + 4 * idx);
               checkOutput("ws0_rdata", busB.rdata, romImage(bAddr[idx]));
            end
            idx++;
            if (idx < 4) busB.addr0 = bAddr[idx];
            else         busB.req0  = 1'b0;
         end
      end
      busB.req0 = 1'b0;
      checkOutput("ws0_read_count", idx, 4);
      checkOutput("ws0_cs_cycles",  csLow, 8);
      checkOutput("ws0_oe_cycles",  oeLow, 4);

      // Reset in the middle of STROBE
      @(negedge clk);
      busA.req0  = 1'b1;
      busA.addr0 = 16'h0042;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("midrst_in_strobe", busA.rom_oe_n, 0);
      reset_n   = 1'b0;
      busA.req0 = 1'b0;
      @(negedge clk);
      checkOutput("midrst_cs_n",  busA.rom_cs_n, 1);
      checkOutput("midrst_oe_n",  busA.rom_oe_n, 1);
      checkOutput("midrst_ack0",  busA.ack0, 0);
      checkOutput("midrst_rdata", busA.rdata, 0);
      checkOutput("midrst_busy",  busA.busy, 0);
      checkOutput("midrst_addr",  busA.rom_addr, 0);
      reset_n  = 1'b1;
      ackCount = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (busA.ack0 || busA.ack1) ackCount++;
      end
      checkOutput("midrst_no_ack", ackCount, 0);
      applyStimulus(1'b0, 16'h0042, 1'b0, ackCycle, ackCount, wrongAck, csLow, oeLow, dataSeen, addrSeen);
      checkOutput("postrst_ack_cycle", ackCycle, 5);
      checkOutput("postrst_rdata",     dataSeen, romImage(16'h0042));

      // req1 dropped during SETUP still completes exactly once
      applyStimulus(1'b1, 16'h0777, 1'b1, ackCycle, ackCount, wrongAck, csLow, oeLow, dataSeen, addrSeen);
      checkOutput("drop_ack1_count", ackCount, 1);
      checkOutput("drop_ack_cycle",  ackCycle, 5);
      checkOutput("drop_wrong_ack",  wrongAck, 0);
      checkOutput("drop_rdata",      dataSeen, romImage(16'h0777));
      checkOutput("drop_cs_cycles",  csLow, 4);
      checkOutput("drop_owner",      busA.owner, 1);

      // Random requests: ack exclusivity and address stability under CS
      bothAck     = 0;
      addrMoves   = 0;
      ackNoBusy   = 0;
      ackOwnerBad = 0;
      ackTotal    = 0;
      prevCsLow   = 1'b0;
      prevAddr    = busA.rom_addr;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         if (busA.ack0 && busA.ack1) bothAck++;
         if (!busA.rom_cs_n && prevCsLow && busA.rom_addr !== prevAddr) addrMoves++;
         if ((busA.ack0 || busA.ack1) && !busA.busy) ackNoBusy++;
         if (busA.ack1 && busA.owner !== 1'b1) ackOwnerBad++;
         if (busA.ack0 && busA.owner !== 1'b0) ackOwnerBad++;
         if (busA.ack0 || busA.ack1) ackTotal++;
         prevCsLow = !busA.rom_cs_n;
         prevAddr  = busA.rom_addr;
         r = $urandom;
         busA.req0 = r[0];
         busA.req1 = r[1];
         if (!busA.req0) busA.addr0 = r[31:16];
         if (!busA.req1) busA.addr1 = {r[15:8], r[23:16]};
      end
      busA.req0 = 1'b0;
      busA.req1 = 1'b0;
      checkOutput("rand_both_ack",    bothAck, 0);
      checkOutput("rand_addr_moved",  addrMoves, 0);
      checkOutput("rand_ack_no_busy", ackNoBusy, 0);
      checkOutput("rand_ack_owner",   ackOwnerBad, 0);
      checkOutput("rand_activity",    (ackTotal > 50), 1);
      repeat (8) @(negedge clk);
      checkOutput("final_busy", busA.busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
